// File: rtl/spiflash_emu_if.sv
// SPI pad and memory-port bundle for spiflash_emu.
//   csb, sck, io_in  : SPI pins from the host (io_in = io3..io0)
//   io_out, io_oe    : pad output data and per-pin output enables
//   mem_addr, mem_re : synchronous memory read port (mem_rdata valid the clk after the read)
//   mem_we, mem_wdata: one-cycle memory write strobe and data
// slave = the emulator, master = the harness hosting the pins and the memory.
interface spiflash_emu_if #(
   parameter int unsigned ADDR_WIDTH = 24
);
   logic                  csb;
   logic                  sck;
   logic [3:0]            io_in;
   logic [3:0]            io_out;
   logic [3:0]            io_oe;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_re;
   logic [7:0]            mem_rdata;
   logic                  mem_we;
   logic [7:0]            mem_wdata;

   modport slave (
      input  csb, sck, io_in, mem_rdata,
      output io_out, io_oe, mem_addr, mem_re, mem_we, mem_wdata
   );

   modport master (
      output csb, sck, io_in, mem_rdata,
      input  io_out, io_oe, mem_addr, mem_re, mem_we, mem_wdata
   );
endinterface

// File: rtl/spiflash_emu.sv
// SPI NOR flash emulator: oversamples the SPI pins on clk and serves single/dual/quad reads
// (with continuous XIP mode), status read, write enable/disable, page program and power down.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : spiflash_emu_if slave (SPI pins + external synchronous memory port)
//   xip_active : continuous mode armed
//   busy       : status WIP bit
module spiflash_emu #(
   parameter int unsigned ADDR_WIDTH   = 24,
   parameter int unsigned DUMMY_CYCLES = 8,
   parameter int unsigned PROG_CYCLES  = 64
) (
   input  logic           clk,
   input  logic           reset,
   spiflash_emu_if.slave  bus,
   output logic           xip_active,
   output logic           busy
);
   localparam logic [7:0] OpRead   = 8'h03;
   localparam logic [7:0] OpFast   = 8'h0B;
   localparam logic [7:0] OpDual   = 8'hBB;
   localparam logic [7:0] OpQuad   = 8'hEB;
   localparam logic [7:0] OpStat   = 8'h05;
   localparam logic [7:0] OpWren   = 8'h06;
   localparam logic [7:0] OpWrdi   = 8'h04;
   localparam logic [7:0] OpProg   = 8'h02;
   localparam logic [7:0] OpPwrUp  = 8'hAB;
   localparam logic [7:0] OpPwrDn  = 8'hB9;
   localparam logic [7:0] OpXipClr = 8'hFF;
   localparam logic [7:0] XipMode  = 8'hA5;
   localparam bit          NoDummy   = (DUMMY_CYCLES == 0);
   localparam logic [7:0]  DummyLast = 8'(DUMMY_CYCLES - 1);
   localparam logic [15:0] ProgLast  = 16'(PROG_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle, StCmd, StAddr, StMode, StDummy, StDataOut, StDataIn, StIgnore
   } state_t;

   // Lane code: 0 = single (io0 in / io1 out), 1 = dual, 2 = quad.
   function automatic logic [1:0] lanes_for(input logic [7:0] op);
      case (op)
         OpDual:  lanes_for = 2'd1;
         OpQuad:  lanes_for = 2'd2;
         default: lanes_for = 2'd0;
      endcase
   endfunction

   state_t                state;
   logic [2:0]            csb_sync, sck_sync;  // [1:0] synchroniser, [2] edge history
   logic [3:0]            io_s1, io_s2;
   logic                  csb_rise, csb_fall, sck_rise, sck_fall;
   logic [7:0]            opcode, xip_op, shreg, cnt, rd_buf, out_sh, mwdata;
   logic [23:0]           addr;
   logic [1:0]            lanes;
   logic [2:0]            out_cnt;
   logic [3:0]            mbr_cnt, dout, doe;
   logic [15:0]           wip_cnt;
   logic                  wel, wip, powered, xip, prog_any, rd_pend, mre, mwe;
   logic [ADDR_WIDTH-1:0] maddr;

   // Next-state views of the input shifters and output serialiser for the current lane width.
   logic [7:0]  sh_next, step, bits_next, out_byte, out_sh_next;
   logic [23:0] addr_next;
   logic [3:0]  io_drv, oe_drv;
   logic [2:0]  byte_last;

   always_comb begin
      sh_next     = {shreg[6:0], io_s2[0]};
      addr_next   = {addr[22:0], io_s2[0]};
      step        = 8'd1;
      out_byte    = out_sh;
      if (out_cnt == 3'd0) out_byte = (opcode == OpStat) ? {6'b0, wel, wip} : rd_buf;
      io_drv      = {2'b00, out_byte[7], 1'b0};
      oe_drv      = 4'b0010;
      out_sh_next = {out_byte[6:0], 1'b0};
      byte_last   = 3'd7;
      case (lanes)
         2'd1: begin
            sh_next     = {shreg[5:0], io_s2[1:0]};
            addr_next   = {addr[21:0], io_s2[1:0]};
            step        = 8'd2;
            io_drv      = {2'b00, out_byte[7:6]};
            oe_drv      = 4'b0011;
            out_sh_next = {out_byte[5:0], 2'b00};
            byte_last   = 3'd3;
         end
         2'd2: begin
            sh_next     = {shreg[3:0], io_s2};
            addr_next   = {addr[19:0], io_s2};
            step        = 8'd4;
            io_drv      = out_byte[7:4];
            oe_drv      = 4'b1111;
            out_sh_next = {out_byte[3:0], 4'b0000};
            byte_last   = 3'd1;
         end
         default: ;
      endcase
      bits_next = cnt + step;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= StIdle;
         csb_sync <= 3'b111;
         sck_sync <= 3'b000;
         io_s1    <= 4'd0;
         io_s2    <= 4'd0;
         csb_rise <= 1'b0;
         csb_fall <= 1'b0;
         sck_rise <= 1'b0;
         sck_fall <= 1'b0;
         opcode   <= 8'd0;
         xip_op   <= 8'd0;
         shreg    <= 8'd0;
         cnt      <= 8'd0;
         rd_buf   <= 8'd0;
         out_sh   <= 8'd0;
         mwdata   <= 8'd0;
         addr     <= 24'd0;
         lanes    <= 2'd0;
         out_cnt  <= 3'd0;
         mbr_cnt  <= 4'd0;
         dout     <= 4'd0;
         doe      <= 4'd0;
         wip_cnt  <= 16'd0;
         wel      <= 1'b0;
         wip      <= 1'b0;
         powered  <= 1'b1;
         xip      <= 1'b0;
         prog_any <= 1'b0;
         rd_pend  <= 1'b0;
         mre      <= 1'b0;
         mwe      <= 1'b0;
         maddr    <= '0;
      end else begin
         csb_sync <= {csb_sync[1:0], bus.csb};
         sck_sync <= {sck_sync[1:0], bus.sck};
         io_s1    <= bus.io_in;
         io_s2    <= io_s1;
         csb_rise <= csb_sync[1] & ~csb_sync[2];
         csb_fall <= ~csb_sync[1] & csb_sync[2];
         sck_rise <= sck_sync[1] & ~sck_sync[2];
         sck_fall <= ~sck_sync[1] & sck_sync[2];
         mre      <= 1'b0;
         mwe      <= 1'b0;
         rd_pend  <= mre;
         if (rd_pend) rd_buf <= bus.mem_rdata;
         if (wip) begin
            if (wip_cnt == 16'd0) wip <= 1'b0;
            else wip_cnt <= wip_cnt - 16'd1;
         end

         if (csb_rise) begin
            state <= StIdle;
            dout  <= 4'd0;
            doe   <= 4'd0;
            if (state == StDataIn && prog_any) begin
               wel     <= 1'b0;
               wip     <= 1'b1;
               wip_cnt <= ProgLast;
            end
            if (mbr_cnt == 4'd8) xip <= 1'b0;
         end else if (csb_fall) begin
            cnt      <= 8'd0;
            mbr_cnt  <= 4'd0;
            prog_any <= 1'b0;
            if (xip) begin
               state  <= StAddr;
               opcode <= xip_op;
               lanes  <= lanes_for(xip_op);
            end else begin
               state <= StCmd;
               lanes <= 2'd0;
            end
         end else if (!csb_sync[2] && sck_rise) begin
            shreg <= sh_next;
            cnt   <= bits_next;
            if (!io_s2[0]) mbr_cnt <= 4'd0;
            else if (mbr_cnt != 4'd9) mbr_cnt <= mbr_cnt + 4'd1;
            case (state)
               StCmd: if (bits_next == 8'd8) begin
                  cnt    <= 8'd0;
                  opcode <= sh_next;
                  state  <= StIgnore;
                  if (!powered) begin
                     if (sh_next == OpPwrUp) powered <= 1'b1;
                  end else if (!wip || sh_next == OpStat) begin
                     case (sh_next)
                        OpRead, OpFast, OpDual, OpQuad: begin
                           state <= StAddr;
                           lanes <= lanes_for(sh_next);
                        end
                        OpStat: begin
                           state   <= StDataOut;
                           out_cnt <= 3'd0;
                        end
                        OpWren:   wel     <= 1'b1;
                        OpWrdi:   wel     <= 1'b0;
                        OpProg:   if (wel) state <= StAddr;
                        OpPwrDn:  powered <= 1'b0;
                        OpXipClr: xip     <= 1'b0;
                        default: ;
                     endcase
                  end
               end
               StAddr: begin
                  addr <= addr_next;
                  if (bits_next == 8'd24) begin
                     cnt     <= 8'd0;
                     maddr   <= addr_next[ADDR_WIDTH-1:0];
                     out_cnt <= 3'd0;
                     case (opcode)
                        OpRead: begin
                           mre   <= 1'b1;
                           state <= StDataOut;
                        end
                        OpFast: begin
                           mre   <= 1'b1;
                           state <= NoDummy ? StDataOut : StDummy;
                        end
                        OpDual, OpQuad: state <= StMode;
                        default: state <= StDataIn;
                     endcase
                  end
               end
               StMode: if (bits_next == 8'd8) begin
                  cnt     <= 8'd0;
                  xip     <= (sh_next == XipMode);
                  xip_op  <= opcode;
                  mre     <= 1'b1;
                  out_cnt <= 3'd0;
                  state   <= NoDummy ? StDataOut : StDummy;
               end
               StDummy: begin
                  cnt <= cnt + 8'd1;
                  if (cnt == DummyLast) state <= StDataOut;
               end
               StDataIn: if (bits_next == 8'd8) begin
                  // Program pointer wraps inside the 256-byte page.
                  cnt       <= 8'd0;
                  mwe       <= 1'b1;
                  mwdata    <= sh_next;
                  maddr     <= addr[ADDR_WIDTH-1:0];
                  addr[7:0] <= addr[7:0] + 8'd1;
                  prog_any  <= 1'b1;
               end
               default: ;
            endcase
         end else if (!csb_sync[2] && sck_fall && state == StDataOut) begin
            dout   <= io_drv;
            doe    <= oe_drv;
            out_sh <= out_sh_next;
            if (out_cnt == 3'd0) begin
               // Starting a byte: prefetch the next one while this one shifts out.
               out_cnt <= byte_last;
               if (opcode != OpStat) begin
                  maddr <= maddr + ADDR_WIDTH'(1);
                  mre   <= 1'b1;
               end
            end else begin
               out_cnt <= out_cnt - 3'd1;
            end
         end
      end
   end

   assign bus.io_out    = dout;
   assign bus.io_oe     = doe;
   assign bus.mem_addr  = maddr;
   assign bus.mem_re    = mre;
   assign bus.mem_we    = mwe;
   assign bus.mem_wdata = mwdata;
   assign xip_active    = xip;
   assign busy          = wip;
endmodule

// File: tb/tb_spiflash_emu.sv
// Directed bench for spiflash_emu: drives SPI mode-0 frames, models the synchronous memory,
// and checks read data, output enables, XIP, program, status, power-down and reset behaviour.
module tb_spiflash_emu;
   localparam int H    = 5;     // clk cycles per SCK half period
   localparam int Prog = 1000;  // long enough to fit status/read frames inside WIP

   logic clk = 1'b0;
   logic reset;
   logic xip_w, busy_w;
   int   checks = 0;
   int   errors = 0;
   int   we_count = 0;
   int   busy_clks = 0;
   logic [7:0]  mem [0:255];
   logic [23:0] wa [0:15];
   logic [7:0]  wd [0:15];
   logic [7:0]  b;
   logic [3:0]  oe, oe_any, oe_acc;

   spiflash_emu_if #(.ADDR_WIDTH(24)) bus ();

   spiflash_emu #(
      .ADDR_WIDTH  (24),
      .DUMMY_CYCLES(8),
      .PROG_CYCLES (Prog)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .xip_active(xip_w),
      .busy      (busy_w)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr[7:0]];
      if (bus.mem_we) begin
         mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
         if (we_count < 16) begin
            wa[we_count] = bus.mem_addr;
            wd[we_count] = bus.mem_wdata;
         end
         we_count++;
      end
   end

   always @(negedge clk) if (busy_w === 1'b1) busy_clks++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic sck_cycle(input logic [3:0] d, output logic [3:0] o, output logic [3:0] e);
      bus.io_in = d;
      repeat (H) @(posedge clk);
      #1;
      o = bus.io_out;
      e = bus.io_oe;
      bus.sck = 1'b1;
      repeat (H) @(posedge clk);
      #1;
      bus.sck = 1'b0;
   endtask

   task automatic cs_low();
      bus.csb = 1'b0;
      repeat (2 * H) @(posedge clk);
      #1;
   endtask

   task automatic cs_high();
      repeat (H) @(posedge clk);
      #1;
      bus.csb = 1'b1;
      repeat (3 * H) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] v, input int ln, output logic [3:0] e_any);
      logic [7:0] s;
      logic [3:0] d, o, e;
      s = v;
      e_any = 4'd0;
      for (int i = 0; i < 8 / ln; i++) begin
         if (ln == 4) d = s[7:4];
         else if (ln == 2) d = {2'b00, s[7:6]};
         else d = {3'b000, s[7]};
         s = s << ln;
         sck_cycle(d, o, e);
         e_any |= e;
      end
   endtask

   task automatic recv_byte(input int ln, output logic [7:0] v, output logic [3:0] e_first);
      logic [3:0] o, e;
      v = 8'd0;
      e_first = 4'd0;
      for (int i = 0; i < 8 / ln; i++) begin
         sck_cycle(4'd0, o, e);
         if (i == 0) e_first = e;
         if (ln == 4) v = {v[3:0], o};
         else if (ln == 2) v = {v[5:0], o[1:0]};
         else v = {v[6:0], o[1]};
      end
   endtask

   task automatic dummy(input int n);
      logic [3:0] o, e;
      for (int i = 0; i < n; i++) sck_cycle(4'd0, o, e);
   endtask

   // Opcode followed by a 24-bit address; returns the OR of io_oe seen throughout.
   task automatic send_cmd_addr(input logic [7:0] op, input logic [23:0] a, input int ln,
                                output logic [3:0] e_any);
      logic [3:0] e;
      send_byte(op, 1, e_any);
      send_byte(a[23:16], ln, e);
      e_any |= e;
      send_byte(a[15:8], ln, e);
      e_any |= e;
      send_byte(a[7:0], ln, e);
      e_any |= e;
   endtask

   task automatic one_byte_cmd(input logic [7:0] op);
      logic [3:0] e;
      cs_low();
      send_byte(op, 1, e);
      cs_high();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[0] = 8'hA5;
      mem[1] = 8'h3C;
      reset = 1'b1;
      bus.csb = 1'b1;
      bus.sck = 1'b0;
      bus.io_in = 4'd0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("rst_io", {bus.io_out, bus.io_oe}, 8'h00);
      check("rst_mem", {bus.mem_addr, bus.mem_re, bus.mem_we, bus.mem_wdata}, 34'h0);
      check("rst_flags", {xip_w, busy_w}, 2'b00);
      reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;

      // Single read of two bytes from 0.
      cs_low();
      send_cmd_addr(8'h03, 24'h000000, 1, oe_any);
      check("rd_cmd_oe", oe_any, 4'h0);
      recv_byte(1, b, oe);
      check("rd_b0", b, 8'hA5);
      check("rd_oe", oe, 4'b0010);
      recv_byte(1, b, oe);
      check("rd_b1", b, 8'h3C);
      cs_high();

      // Quad I/O read arming XIP, then an opcode-less continuation frame.
      cs_low();
      send_cmd_addr(8'hEB, 24'h000000, 4, oe_any);
      send_byte(8'hA5, 4, oe);
      oe_any |= oe;
      dummy(8);
      check("eb_pre_oe", oe_any, 4'h0);
      recv_byte(4, b, oe);
      check("eb_b0", b, 8'hA5);
      check("eb_oe", oe, 4'b1111);
      recv_byte(4, b, oe);
      check("eb_b1", b, 8'h3C);
      cs_high();
      check("eb_xip", xip_w, 1'b1);
      cs_low();
      send_byte(8'h00, 4, oe);
      send_byte(8'h00, 4, oe);
      send_byte(8'h01, 4, oe);
      send_byte(8'hA5, 4, oe);
      dummy(8);
      recv_byte(4, b, oe);
      check("xip_b", b, 8'h3C);
      cs_high();
      check("xip_kept", xip_w, 1'b1);

      // Mode-bit reset: 8 clocks with io0 high, then CSB high.
      cs_low();
      for (int i = 0; i < 8; i++) sck_cycle(4'b0001, b[3:0], oe);
      cs_high();
      check("mbr_xip", xip_w, 1'b0);

      // Power down blocks reads; power up restores them.
      one_byte_cmd(8'hB9);
      cs_low();
      send_cmd_addr(8'h03, 24'h000000, 1, oe_any);
      recv_byte(1, b, oe);
      check("pd_oe", oe, 4'h0);
      cs_high();
      one_byte_cmd(8'hAB);
      cs_low();
      send_cmd_addr(8'h03, 24'h000001, 1, oe_any);
      recv_byte(1, b, oe);
      check("pu_b", b, 8'h3C);
      check("pu_oe", oe, 4'b0010);
      cs_high();

      // Program without write enable is ignored.
      cs_low();
      send_cmd_addr(8'h02, 24'h0000FE, 1, oe_any);
      send_byte(8'h11, 1, oe);
      cs_high();
      check("np_we", we_count, 0);
      check("np_busy", busy_w, 1'b0);

      one_byte_cmd(8'h06);
      cs_low();
      send_byte(8'h05, 1, oe);
      recv_byte(1, b, oe);
      check("st_wel", b, 8'h02);
      cs_high();

      // Page program crossing the page end.
      cs_low();
      send_cmd_addr(8'h02, 24'h0000FE, 1, oe_any);
      send_byte(8'h11, 1, oe);
      send_byte(8'h22, 1, oe);
      send_byte(8'h33, 1, oe);
      bus.csb = 1'b1;
      for (int i = 0; i < 50 && busy_w !== 1'b1; i++) @(negedge clk);
      check("pp_busy", busy_w, 1'b1);
      check("pp_cnt", we_count, 3);
      check("pp_w0", {wa[0], wd[0]}, 32'h0000FE11);
      check("pp_w1", {wa[1], wd[1]}, 32'h0000FF22);
      check("pp_w2", {wa[2], wd[2]}, 32'h00000033);
      repeat (2 * H) @(posedge clk);
      #1;

      // Status and read while WIP is set.
      cs_low();
      send_byte(8'h05, 1, oe);
      recv_byte(1, b, oe);
      check("wip_st0", b, 8'h01);
      recv_byte(1, b, oe);
      check("wip_st1", b, 8'h01);
      cs_high();
      cs_low();
      send_cmd_addr(8'h03, 24'h000000, 1, oe_any);
      recv_byte(1, b, oe);
      check("wip_rd_oe", oe_any | oe, 4'h0);
      cs_high();
      for (int i = 0; i < 3000 && busy_w !== 1'b0; i++) @(negedge clk);
      check("wip_end", busy_w, 1'b0);
      check("wip_len", busy_clks, Prog);
      #1;
      cs_low();
      send_byte(8'h05, 1, oe);
      recv_byte(1, b, oe);
      check("st_done", b, 8'h00);
      cs_high();
      cs_low();
      send_cmd_addr(8'h03, 24'h0000FE, 1, oe_any);
      recv_byte(1, b, oe);
      check("rb_fe", b, 8'h11);
      recv_byte(1, b, oe);
      check("rb_ff", b, 8'h22);
      recv_byte(1, b, oe);
      check("rb_100", b, 8'h33);
      cs_high();

      // Reset in the middle of a program byte.
      one_byte_cmd(8'h06);
      cs_low();
      send_cmd_addr(8'h02, 24'h000010, 1, oe_any);
      for (int i = 0; i < 4; i++) sck_cycle(4'b0001, b[3:0], oe);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      bus.csb = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("mr_io", {bus.io_out, bus.io_oe}, 8'h00);
      check("mr_mem", {bus.mem_addr, bus.mem_re, bus.mem_we, bus.mem_wdata}, 34'h0);
      check("mr_flags", {xip_w, busy_w}, 2'b00);
      reset = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("mr_we", we_count, 3);
      cs_low();
      send_byte(8'h05, 1, oe);
      recv_byte(1, b, oe);
      check("mr_st", b, 8'h00);
      cs_high();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
